// File: rtl/cfg_spi_pkg.sv
// Shared constants for the SPI-to-config-bus bridge: FSM encodings, opcodes,
// status-byte layout and the minimum clk/sclk frequency ratio.
package cfg_spi_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] ST_WAIT_CS_HI = 3'd0;
  localparam logic [2:0] ST_IDLE       = 3'd1;
  localparam logic [2:0] ST_CMD        = 3'd2;
  localparam logic [2:0] ST_ADDR       = 3'd3;
  localparam logic [2:0] ST_DATA       = 3'd4;
  localparam logic [2:0] ST_STAT       = 3'd5;
  localparam logic [2:0] ST_IGNORE     = 3'd6;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  localparam int unsigned STAT_ABORT_BIT = 7;
  localparam int unsigned STAT_ERR_LSB   = 0;
  localparam int unsigned STAT_ERR_W     = 7;

  localparam int unsigned MIN_CLK_PER_SCLK = 8;

  function automatic logic [7:0] status_byte(input logic abort,
                                             input logic [STAT_ERR_W-1:0] err);
    logic [7:0] s;
    s = '0;
    s[STAT_ABORT_BIT] = abort;
    s[STAT_ERR_LSB +: STAT_ERR_W] = err;
    return s;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with one-clk
// rise/fall pulses taken from the last stage against a delay flop.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("spi_in_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_c  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_c  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/cfg_spi_bridge.sv
// SPI mode-0 slave that turns write frames into one-clk config-bus strobes
// and serves a status byte (abort flag + saturating frame-error count).
module cfg_spi_bridge
  import cfg_spi_pkg::*;
#(
  parameter int unsigned CFG_ADDR_WIDTH = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned ERR_CNT_W      = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_sclk,
  input  logic                      spi_cs_n,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  output logic                      cfg_we,
  output logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
  output logic [7:0]                cfg_wdata,
  output logic                      busy
);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din_i(spi_sclk),
    .level_o(sclk_lvl_unused), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din_i(spi_cs_n),
    .level_o(cs_lvl), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din_i(spi_mosi),
    .level_o(mosi_lvl), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  logic [STATE_W-1:0]        state_q, state_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [6:0]                shin_q, shin_d;
  logic [7:0]                shout_q, shout_d;
  logic [7:0]                stat_val_q, stat_val_d;
  logic                      stat_cap_q, stat_cap_d;
  logic                      stat_done_q, stat_done_d;
  logic [CFG_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ERR_CNT_W-1:0]      err_q, err_d;
  logic                      abort_q, abort_d;
  logic                      we_q, we_d;
  logic [CFG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                wdata_q, wdata_d;
  logic                      miso_q, miso_d;
  logic                      oe_q, oe_d;
  logic                      busy_q, busy_d;

  logic [7:0] rx_byte;
  logic [7:0] status_now;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // Next-state / datapath: frame open, bit shifting, byte dispatch, frame close
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    stat_val_d  = stat_val_q;
    stat_cap_d  = stat_cap_q;
    stat_done_d = stat_done_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    abort_d     = abort_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    rx_byte     = {shin_q, mosi_lvl};
    status_now  = stat_cap_q ? stat_val_q
                             : status_byte(abort_q, STAT_ERR_W'(err_q));

    if (state_q == ST_WAIT_CS_HI) begin
      if (cs_lvl) state_d = ST_IDLE;
    end else if (cs_fall) begin
      // A falling cs_n outside IDLE is a glitch: restart and count it
      if (state_q != ST_IDLE) err_d = sat_inc(err_q);
      state_d     = ST_CMD;
      bit_cnt_d   = 3'd0;
      stat_cap_d  = 1'b0;
      stat_done_d = 1'b0;
      oe_d        = 1'b0;
      miso_d      = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sclk_rise) begin
        shin_d    = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              if (rx_byte == CMD_WRITE) begin
                state_d = ST_ADDR;
              end else if (rx_byte == CMD_STATUS) begin
                state_d = ST_STAT;
                oe_d    = 1'b1;
              end else begin
                state_d = ST_IGNORE;
                err_d   = sat_inc(err_q);
              end
            end
            ST_ADDR: begin
              ptr_d   = CFG_ADDR_WIDTH'(rx_byte);
              state_d = ST_DATA;
            end
            ST_DATA: begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              wdata_d = rx_byte;
              ptr_d   = ptr_q + CFG_ADDR_WIDTH'(1);
            end
            ST_STAT: stat_done_d = 1'b1;
            default: ;
          endcase
        end
      end

      // Status is frozen at the first falling edge and replayed every byte
      if (sclk_fall && state_q == ST_STAT) begin
        if (bit_cnt_q == 3'd0) begin
          stat_val_d = status_now;
          stat_cap_d = 1'b1;
          miso_d     = status_now[7];
          shout_d    = {status_now[6:0], 1'b0};
        end else begin
          miso_d  = shout_q[7];
          shout_d = {shout_q[6:0], 1'b0};
        end
      end

      // Close after any byte completing this cycle has been dispatched
      if (cs_rise) begin
        if (state_q == ST_STAT && stat_done_d) begin
          err_d   = '0;
          abort_d = 1'b0;
        end
        if (bit_cnt_d != 3'd0) begin
          abort_d = 1'b1;
          err_d   = sat_inc(err_d);
        end
        state_d = ST_IDLE;
        oe_d    = 1'b0;
        miso_d  = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_WAIT_CS_HI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_CS_HI;
      bit_cnt_q   <= 3'd0;
      shin_q      <= '0;
      shout_q     <= '0;
      stat_val_q  <= '0;
      stat_cap_q  <= 1'b0;
      stat_done_q <= 1'b0;
      ptr_q       <= '0;
      err_q       <= '0;
      abort_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      stat_val_q  <= stat_val_d;
      stat_cap_q  <= stat_cap_d;
      stat_done_q <= stat_done_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign cfg_we      = we_q;
  assign cfg_addr    = addr_q;
  assign cfg_wdata   = wdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cfg_spi_bridge.sv
// Directed bench for cfg_spi_bridge: an SPI master model drives frames and
// each scenario task checks strobes, status bytes and flags against constants.
module tb_cfg_spi_bridge;
  import cfg_spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       cfg_we;
  logic [7:0] cfg_addr, cfg_wdata;
  logic       busy;

  cfg_spi_bridge #(.CFG_ADDR_WIDTH(8), .SYNC_STAGES(2), .ERR_CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int hp      = 6;
  int phase   = 1;
  int oe_cnt  = 0;
  int wide_cnt = 0;
  logic        we_prev = 1'b0;
  logic [15:0] mon_q[$];

  // Strobe monitor on the inactive edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_we) mon_q.push_back({cfg_addr, cfg_wdata});
      if (cfg_we && we_prev) wide_cnt++;
    end
    we_prev <= cfg_we;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no end want end");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #(phase);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, input bit close_last,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nb; i--) begin
      spi_mosi = tx[i];
      clks(hp);
      rx[i] = spi_miso;
      if (spi_miso_oe === 1'b1) oe_cnt++;
      spi_sclk = 1'b1;
      if (close_last && i == 8 - nb) spi_cs_n = 1'b1;
      clks(hp);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    clks(hp);
  endtask

  task automatic cs_high();
    clks(hp);
    spi_cs_n = 1'b1;
    clks(2 * hp + 6);
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx;
    spi_bits(b, 8, 1'b0, rx);
  endtask

  task automatic read_status(output logic [7:0] b0, output logic [7:0] b1,
                             output int oe_cmd, output int oe_stat);
    logic [7:0] rx;
    cs_low();
    oe_cnt = 0;
    spi_bits(CMD_STATUS, 8, 1'b0, rx);
    oe_cmd = oe_cnt;
    oe_cnt = 0;
    spi_bits(8'h00, 8, 1'b0, b0);
    spi_bits(8'h00, 8, 1'b0, b1);
    oe_stat = oe_cnt;
    cs_high();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    clks(4);
    n_total++; if (cfg_we !== 1'b0) $display("FAIL reset_we: got %b want 0", cfg_we); else n_pass++;
    n_total++; if (cfg_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", cfg_addr); else n_pass++;
    n_total++; if (cfg_wdata !== 8'h00) $display("FAIL reset_wdata: got %h want 00", cfg_wdata); else n_pass++;
    n_total++; if ({spi_miso, spi_miso_oe, busy} !== 3'b000)
      $display("FAIL reset_miso_oe_busy: got %b want 000", {spi_miso, spi_miso_oe, busy}); else n_pass++;
    rst_n = 1'b1;
    clks(8);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single_write();
    logic [7:0] s0, s1;
    int oc, os;
    mon_q.delete();
    cs_low();
    send(CMD_WRITE); send(8'h10);
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy_open: got %b want 1", busy); else n_pass++;
    send(8'h5A);
    cs_high();
    n_total++; if (mon_q.size() != 1) $display("FAIL single_count: got %0d want 1", mon_q.size()); else n_pass++;
    n_total++; if (((mon_q.size() > 0) ? mon_q[0] : 16'hxxxx) !== 16'h105A)
      $display("FAIL single_strobe: got %h want 105a", (mon_q.size() > 0) ? mon_q[0] : 16'hxxxx); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_closed: got %b want 0", busy); else n_pass++;
    read_status(s0, s1, oc, os);
    n_total++; if (s0 !== 8'h00) $display("FAIL single_status: got %h want 00", s0); else n_pass++;
  endtask

  task automatic test_burst_wrap();
    mon_q.delete();
    wide_cnt = 0;
    cs_low();
    send(CMD_WRITE); send(8'hFE); send(8'h11); send(8'h22); send(8'h33);
    cs_high();
    n_total++; if (mon_q.size() != 3) $display("FAIL burst_count: got %0d want 3", mon_q.size()); else n_pass++;
    n_total++; if (((mon_q.size() > 0) ? mon_q[0] : 16'hxxxx) !== 16'hFE11)
      $display("FAIL burst_0: got %h want fe11", (mon_q.size() > 0) ? mon_q[0] : 16'hxxxx); else n_pass++;
    n_total++; if (((mon_q.size() > 1) ? mon_q[1] : 16'hxxxx) !== 16'hFF22)
      $display("FAIL burst_1: got %h want ff22", (mon_q.size() > 1) ? mon_q[1] : 16'hxxxx); else n_pass++;
    n_total++; if (((mon_q.size() > 2) ? mon_q[2] : 16'hxxxx) !== 16'h0033)
      $display("FAIL burst_wrap: got %h want 0033", (mon_q.size() > 2) ? mon_q[2] : 16'hxxxx); else n_pass++;
    n_total++; if (wide_cnt != 0) $display("FAIL burst_width: got %0d wide strobes want 0", wide_cnt); else n_pass++;
  endtask

  task automatic test_abort_status();
    logic [7:0] s0, s1, rx;
    int oc, os;
    mon_q.delete();
    cs_low();
    send(CMD_WRITE); send(8'hC0);
    spi_bits(8'hA5, 5, 1'b0, rx);
    cs_high();
    n_total++; if (mon_q.size() != 0) $display("FAIL abort_no_strobe: got %0d want 0", mon_q.size()); else n_pass++;
    read_status(s0, s1, oc, os);
    n_total++; if (s0 !== 8'h81) $display("FAIL abort_status0: got %h want 81", s0); else n_pass++;
    n_total++; if (s1 !== 8'h81) $display("FAIL abort_status1: got %h want 81", s1); else n_pass++;
    n_total++; if (oc != 0) $display("FAIL abort_oe_cmd: got %0d high samples want 0", oc); else n_pass++;
    n_total++; if (os != 16) $display("FAIL abort_oe_stat: got %0d high samples want 16", os); else n_pass++;
    n_total++; if (spi_miso_oe !== 1'b0) $display("FAIL abort_oe_closed: got %b want 0", spi_miso_oe); else n_pass++;
    read_status(s0, s1, oc, os);
    n_total++; if (s0 !== 8'h00) $display("FAIL abort_status_cleared: got %h want 00", s0); else n_pass++;
  endtask

  task automatic test_bad_cmd();
    logic [7:0] s0, s1;
    int oc, os;
    mon_q.delete();
    cs_low();
    send(8'h7E); send(8'h10); send(8'h55);
    cs_high();
    n_total++; if (mon_q.size() != 0) $display("FAIL badcmd_no_strobe: got %0d want 0", mon_q.size()); else n_pass++;
    read_status(s0, s1, oc, os);
    n_total++; if (s0 !== 8'h01) $display("FAIL badcmd_status: got %h want 01", s0); else n_pass++;
    hp = MIN_CLK_PER_SCLK / 2;
    for (int f = 0; f < 130; f++) begin
      cs_low(); send(8'h7E); cs_high();
    end
    hp = 6;
    read_status(s0, s1, oc, os);
    n_total++; if (s0 !== 8'h7F) $display("FAIL badcmd_saturate: got %h want 7f", s0); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] s0, s1, rx;
    int oc, os;
    mon_q.delete();
    cs_low();
    send(CMD_WRITE); send(8'h20);
    spi_bits(8'hC3, 4, 1'b0, rx);
    n_total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy_async: got %b want 0", busy); else n_pass++;
    n_total++; if (cfg_wdata !== 8'h00) $display("FAIL rstmid_wdata_async: got %h want 00", cfg_wdata); else n_pass++;
    clks(3);
    rst_n = 1'b1;
    clks(4);
    spi_bits(8'hC3, 4, 1'b0, rx);
    send(8'h77);
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy_ignored: got %b want 0", busy); else n_pass++;
    cs_high();
    n_total++; if (mon_q.size() != 0) $display("FAIL rstmid_no_strobe: got %0d want 0", mon_q.size()); else n_pass++;
    cs_low();
    send(CMD_WRITE); send(8'h21); send(8'hAB);
    cs_high();
    n_total++; if (((mon_q.size() == 1) ? mon_q[0] : 16'hxxxx) !== 16'h21AB)
      $display("FAIL rstmid_fresh_write: got %h want 21ab (count %0d)",
               (mon_q.size() > 0) ? mon_q[0] : 16'hxxxx, mon_q.size()); else n_pass++;
    read_status(s0, s1, oc, os);
    n_total++; if (s0 !== 8'h00) $display("FAIL rstmid_status: got %h want 00", s0); else n_pass++;
  endtask

  task automatic test_boundary();
    logic [7:0]  a, d0, d1, rx, s0, s1;
    logic [15:0] exp_q[$];
    int oc, os;
    mon_q.delete();
    hp = MIN_CLK_PER_SCLK / 2;
    for (int f = 0; f < 4; f++) begin
      a  = 8'($urandom_range(0, 255));
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      exp_q.push_back({a, d0});
      exp_q.push_back({a + 8'd1, d1});
      phase = $urandom_range(1, 9);
      clks(1);
      cs_low();
      send(CMD_WRITE); send(a); send(d0);
      spi_bits(d1, 8, 1'b1, rx);
      clks(2 * hp + 6);
    end
    hp = 6;
    phase = 1;
    clks(1);
    n_total++; if (mon_q.size() != exp_q.size())
      $display("FAIL boundary_count: got %0d want %0d", mon_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (((mon_q.size() > i) ? mon_q[i] : 16'hxxxx) !== exp_q[i])
        $display("FAIL boundary_write%0d: got %h want %h", i,
                 (mon_q.size() > i) ? mon_q[i] : 16'hxxxx, exp_q[i]);
      else n_pass++;
    end
    read_status(s0, s1, oc, os);
    n_total++; if (s0 !== 8'h00) $display("FAIL boundary_status: got %h want 00", s0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_abort_status();
    test_bad_cmd();
    test_reset_mid_frame();
    test_boundary();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
